// File: rtl/mem_traffic_pkg.sv
// Shared types and helpers for the memory traffic generator: FSM encoding,
// Galois LFSR tap masks and a saturating increment.
package mem_traffic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Right-shift Galois masks: x^32+x^22+x^2+x+1 and x^64+x^63+x^61+x^60+1
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  localparam int SAT_W = 64;

  // Increment a w-bit counter carried in a SAT_W-bit container, sticking at all ones.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int unsigned w);
    logic [SAT_W-1:0] lim;
    lim = (w >= SAT_W) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? v : v + 64'd1;
  endfunction

  function automatic logic [63:0] lfsr_taps(input int unsigned w);
    return (w == 64) ? LFSR_TAPS_64 : 64'(LFSR_TAPS_32);
  endfunction

endpackage

// File: rtl/mem_bus_cmp.sv
// Cycle-by-cycle comparison of two cache output buses with saturating
// mismatch statistics, cleared when a new run starts.
module mem_bus_cmp
  import mem_traffic_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_active,
  input  logic [CNT_W-1:0]  i_cycle,
  input  logic              i_a_valid,
  input  logic              i_b_valid,
  input  logic              i_a_ready,
  input  logic              i_b_ready,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [STRB_W-1:0] i_a_wstrb,
  input  logic [STRB_W-1:0] i_b_wstrb,
  input  logic [DATA_W-1:0] i_a_wdata,
  input  logic [DATA_W-1:0] i_b_wdata,
  input  logic [DATA_W-1:0] i_a_rdata,
  input  logic [DATA_W-1:0] i_b_rdata,
  output logic [CNT_W-1:0]  o_mismatch_cnt,
  output logic [CNT_W-1:0]  o_first_mm_cycle,
  output logic              o_mm_seen
);

  logic w_differ;
  logic w_mismatch;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_first;
  logic             r_seen;

  assign w_differ = (i_a_valid != i_b_valid) | (i_a_ready != i_b_ready) |
                    (i_a_addr  != i_b_addr)  | (i_a_wstrb != i_b_wstrb) |
                    (i_a_wdata != i_b_wdata) | (i_a_rdata != i_b_rdata);

  // Idle buses (neither side valid) are never a mismatch, whatever the other fields hold.
  assign w_mismatch = i_active & (i_a_valid | i_b_valid) & w_differ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_first <= '0;
      r_seen  <= 1'b0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_first <= '0;
      r_seen  <= 1'b0;
    end else if (w_mismatch) begin
      r_cnt <= CNT_W'(sat_inc(64'(r_cnt), CNT_W));
      if (!r_seen) begin
        r_seen  <= 1'b1;
        r_first <= i_cycle;
      end
    end
  end

  assign o_mismatch_cnt   = r_cnt;
  assign o_first_mm_cycle = r_first;
  assign o_mm_seen        = r_seen;

endmodule

// File: rtl/mem_traffic_gen.sv
// Alternating write/read traffic generator for a valid/ready memory bus plus a
// dual-bus checker. Define MEM_TRAFFIC_LFSR_EN for LFSR data instead of a ramp.
module mem_traffic_gen
  import mem_traffic_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = DATA_W / 8,
  parameter int PHASE_LEN   = 500,
  parameter int NUM_ROUNDS  = 6,
  parameter int ADDR_STRIDE = 4,
  parameter int DATA_STEP   = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_base,
  input  logic [ADDR_W-1:0] addr_mask,
  input  logic              mem_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              cmp_a_valid,
  input  logic              cmp_b_valid,
  input  logic              cmp_a_ready,
  input  logic              cmp_b_ready,
  input  logic [ADDR_W-1:0] cmp_a_addr,
  input  logic [ADDR_W-1:0] cmp_b_addr,
  input  logic [STRB_W-1:0] cmp_a_wstrb,
  input  logic [STRB_W-1:0] cmp_b_wstrb,
  input  logic [DATA_W-1:0] cmp_a_wdata,
  input  logic [DATA_W-1:0] cmp_b_wdata,
  input  logic [DATA_W-1:0] cmp_a_rdata,
  input  logic [DATA_W-1:0] cmp_b_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  first_mm_cycle,
  output logic              mm_seen,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat transfers on any rising edge where mem_valid & mem_ready;
  // until then addr/wstrb/wdata/rdata are held, and mem_valid never drops mid-run.
  localparam int BEAT_W  = $clog2(PHASE_LEN + 1);
  localparam int ROUND_W = $clog2(NUM_ROUNDS + 1);

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_base, r_mask, r_offset;
  logic [BEAT_W-1:0]   r_beat;
  logic [ROUND_W-1:0]  r_round;
  logic [DATA_W-1:0]   r_data, w_data_next, w_rdata;
  logic [CNT_W-1:0]    r_cycle;
  logic w_busy, w_start, w_accept, w_last_beat, w_last_round;

  assign w_busy       = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_start      = (r_state == S_IDLE) && start;
  assign w_accept     = w_busy && mem_ready;
  assign w_last_beat  = (r_beat == BEAT_W'(PHASE_LEN - 1));
  assign w_last_round = (r_round == ROUND_W'(NUM_ROUNDS - 1));

`ifdef MEM_TRAFFIC_LFSR_EN
  localparam logic [DATA_W-1:0] SEED = DATA_W'(1);
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
  assign w_data_next = (r_data >> 1) ^ (r_data[0] ? TAPS : '0);
  assign w_rdata     = {<<{r_data}};
`else
  localparam logic [DATA_W-1:0] SEED = '0;
  assign w_data_next = r_data + DATA_W'(DATA_STEP);
  assign w_rdata     = r_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WRITE;
      S_WRITE: if (w_accept && w_last_beat) w_next = S_READ;
      S_READ:  if (w_accept && w_last_beat) w_next = w_last_round ? S_DONE : S_WRITE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base   <= '0;
      r_mask   <= '0;
      r_offset <= '0;
      r_beat   <= '0;
      r_round  <= '0;
      r_data   <= '0;
      r_cycle  <= '0;
    end else if (w_start) begin
      r_base   <= addr_base;
      r_mask   <= addr_mask;
      r_offset <= '0;
      r_beat   <= '0;
      r_round  <= '0;
      r_data   <= SEED;
      r_cycle  <= '0;
    end else if (w_busy) begin
      r_cycle <= CNT_W'(sat_inc(64'(r_cycle), CNT_W));
      if (w_accept) begin
        r_offset <= r_offset + ADDR_W'(ADDR_STRIDE);
        r_data   <= w_data_next;
        r_beat   <= w_last_beat ? '0 : r_beat + 1'b1;
        if (r_state == S_READ && w_last_beat) r_round <= r_round + 1'b1;
      end
    end
  end

  assign mem_valid = w_busy;
  assign mem_addr  = w_busy ? r_base + (r_offset & r_mask) : '0;
  assign mem_wstrb = (r_state == S_WRITE) ? '1 : '0;
  assign mem_wdata = w_busy ? r_data : '0;
  assign mem_rdata = w_busy ? w_rdata : '0;
  assign busy      = w_busy;
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  mem_bus_cmp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .CNT_W(CNT_W)
  ) u_cmp (
    .clk              (clk),
    .rst              (reset),
    .i_clear          (w_start),
    .i_active         (w_busy),
    .i_cycle          (r_cycle),
    .i_a_valid        (cmp_a_valid),
    .i_b_valid        (cmp_b_valid),
    .i_a_ready        (cmp_a_ready),
    .i_b_ready        (cmp_b_ready),
    .i_a_addr         (cmp_a_addr),
    .i_b_addr         (cmp_b_addr),
    .i_a_wstrb        (cmp_a_wstrb),
    .i_b_wstrb        (cmp_b_wstrb),
    .i_a_wdata        (cmp_a_wdata),
    .i_b_wdata        (cmp_b_wdata),
    .i_a_rdata        (cmp_a_rdata),
    .i_b_rdata        (cmp_b_rdata),
    .o_mismatch_cnt   (mismatch_cnt),
    .o_first_mm_cycle (first_mm_cycle),
    .o_mm_seen        (mm_seen)
  );

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Bench for mem_traffic_gen: beat-level reference model of address/strobe/data
// sequences and mismatch statistics, with directed and randomized runs.
module tb_mem_traffic_gen;

  localparam int ADDR_W = 32, DATA_W = 32, STRB_W = 4;
  localparam int PHASE_LEN = 4, NUM_ROUNDS = 2, ADDR_STRIDE = 4, DATA_STEP = 3, CNT_W = 4;
  localparam int BEATS = 2 * PHASE_LEN * NUM_ROUNDS;
  localparam int ENT_W = ADDR_W + STRB_W + 2 * DATA_W;
  localparam int CYC_LIMIT = 2000;
  localparam int CNT_MAXI = (1 << CNT_W) - 1;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mem_ready = 1'b0;
  logic [ADDR_W-1:0] addr_base = '0, addr_mask = '0;
  logic mem_valid, busy, done, mm_seen;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0] mismatch_cnt, first_mm_cycle;
  logic [1:0] dbg_state;
  logic cmp_a_valid, cmp_b_valid, cmp_a_ready, cmp_b_ready;
  logic [ADDR_W-1:0] cmp_a_addr, cmp_b_addr;
  logic [STRB_W-1:0] cmp_a_wstrb, cmp_b_wstrb;
  logic [DATA_W-1:0] cmp_a_wdata, cmp_b_wdata, cmp_a_rdata, cmp_b_rdata;

  logic corrupt_on = 1'b0;
  int   corrupt_sel = 0;

  int n_tests = 0, n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign cmp_a_valid = mem_valid;
  assign cmp_a_ready = mem_ready;
  assign cmp_a_addr  = mem_addr;
  assign cmp_a_wstrb = mem_wstrb;
  assign cmp_a_wdata = mem_wdata;
  assign cmp_a_rdata = mem_rdata;
  assign cmp_b_valid = mem_valid ^ (corrupt_on && corrupt_sel == 5);
  assign cmp_b_ready = mem_ready ^ (corrupt_on && corrupt_sel == 4);
  assign cmp_b_addr  = mem_addr ^ ADDR_W'(corrupt_on && corrupt_sel == 1);
  assign cmp_b_wstrb = mem_wstrb ^ STRB_W'(corrupt_on && corrupt_sel == 3);
  assign cmp_b_wdata = mem_wdata ^ DATA_W'(corrupt_on && corrupt_sel == 0);
  assign cmp_b_rdata = mem_rdata ^ DATA_W'(corrupt_on && corrupt_sel == 2);

  mem_traffic_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .PHASE_LEN(PHASE_LEN),
    .NUM_ROUNDS(NUM_ROUNDS), .ADDR_STRIDE(ADDR_STRIDE), .DATA_STEP(DATA_STEP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .addr_base(addr_base), .addr_mask(addr_mask),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cmp_a_valid(cmp_a_valid), .cmp_b_valid(cmp_b_valid),
    .cmp_a_ready(cmp_a_ready), .cmp_b_ready(cmp_b_ready),
    .cmp_a_addr(cmp_a_addr), .cmp_b_addr(cmp_b_addr),
    .cmp_a_wstrb(cmp_a_wstrb), .cmp_b_wstrb(cmp_b_wstrb),
    .cmp_a_wdata(cmp_a_wdata), .cmp_b_wdata(cmp_b_wdata),
    .cmp_a_rdata(cmp_a_rdata), .cmp_b_rdata(cmp_b_rdata),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
    .first_mm_cycle(first_mm_cycle), .mm_seen(mm_seen), .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] obs_q[$];
  logic [ENT_W-1:0] cyc_bus_q[$];
  bit               cyc_rdy_q[$];
  int busy_cnt, done_at, done_pulses, exp_mm, exp_first, stall_cycles;
  bit timed_out, exp_seen, rst_hit;
  logic [ENT_W+6:0] rst_snap;
  logic [2*CNT_W:0] rst_stats;

  // Reference beat k: address offset k*stride masked, strobe by phase parity,
  // data a ramp (or LFSR walk from seed 1, reversed for rdata).
  task automatic build_exp(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] mask);
    logic [DATA_W-1:0] d, rv;
    logic [ADDR_W-1:0] a;
    logic [STRB_W-1:0] s;
    exp_q.delete();
`ifdef MEM_TRAFFIC_LFSR_EN
    d = DATA_W'(1);
`else
    d = '0;
`endif
    for (int k = 0; k < BEATS; k++) begin
      a = base + (ADDR_W'(k * ADDR_STRIDE) & mask);
      s = ((k / PHASE_LEN) % 2 == 0) ? '1 : '0;
`ifdef MEM_TRAFFIC_LFSR_EN
      for (int b = 0; b < DATA_W; b++) rv[b] = d[DATA_W-1-b];
      exp_q.push_back({a, s, d, rv});
      d = (d >> 1) ^ (d[0] ? 32'h8020_0003 : 32'h0);
`else
      d = DATA_W'(k * DATA_STEP);
      exp_q.push_back({a, s, d, d});
`endif
    end
  endtask

  // driver: one run from start to done (or reset abort), logging the bus
  task automatic run_traffic(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] mask,
                             input bit rnd_ready, input int stall_beat, input int stall_len,
                             input int corr_at, input int corr_len, input bit rnd_corr,
                             input int sel, input bit glitch, input int reset_beat);
    int cyc, beats, stalled, run_cyc;
    bit fin;
    obs_q.delete(); cyc_bus_q.delete(); cyc_rdy_q.delete();
    busy_cnt = 0; done_at = -1; done_pulses = 0; timed_out = 0; stall_cycles = 0;
    exp_mm = 0; exp_first = 0; exp_seen = 0; rst_hit = 0;
    cyc = 0; beats = 0; stalled = 0; fin = 0;
    @(negedge clk);
    addr_base = base; addr_mask = mask; start = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; addr_base = $urandom; addr_mask = $urandom;
    while (!fin) begin
      cyc++;
      start = 1'b0; corrupt_on = 1'b0; mem_ready = 1'b0;
      if (done) done_pulses++;
      if (busy && reset_beat >= 0 && beats == reset_beat) begin
        reset = 1'b1;
        #1;
        rst_snap = {mem_valid, mem_addr, mem_wstrb, mem_wdata, mem_rdata, busy, done, dbg_state, mm_seen, 2'b00};
        rst_stats = {mismatch_cnt, first_mm_cycle, mm_seen};
        rst_hit = 1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (done) done_pulses++;
        end
        reset = 1'b0;
        fin = 1;
      end else if (busy) begin
        run_cyc = busy_cnt;
        busy_cnt++;
        if (rnd_ready) mem_ready = ($urandom_range(0, 3) != 0);
        else if (beats == stall_beat && stalled < stall_len) begin
          mem_ready = 1'b0;
          stalled++;
        end else mem_ready = 1'b1;
        if (!mem_ready) stall_cycles++;
        corrupt_on  = rnd_corr ? ($urandom_range(0, 4) == 0) : (run_cyc >= corr_at && run_cyc < corr_at + corr_len);
        corrupt_sel = rnd_corr ? $urandom_range(0, 5) : sel;
        if (corrupt_on) begin
          if (!exp_seen) exp_first = (run_cyc > CNT_MAXI) ? CNT_MAXI : run_cyc;
          exp_seen = 1;
          if (exp_mm < CNT_MAXI) exp_mm++;
        end
        if (glitch && run_cyc == 3) begin
          start = 1'b1; addr_base = $urandom; addr_mask = $urandom;
        end
        cyc_bus_q.push_back({mem_addr, mem_wstrb, mem_wdata, mem_rdata});
        cyc_rdy_q.push_back(mem_ready);
        if (mem_valid && mem_ready) begin
          obs_q.push_back({mem_addr, mem_wstrb, mem_wdata, mem_rdata});
          beats++;
        end
      end else if (done) begin
        done_at = cyc;
        fin = 1;
      end
      if (cyc >= CYC_LIMIT) begin
        timed_out = 1;
        fin = 1;
      end
      @(negedge clk);
    end
    corrupt_on = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (done) done_pulses++;
      @(negedge clk);
    end
    if (timed_out) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, mem_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_bus got %h exp 0", {mem_valid, mem_addr, mem_wstrb, mem_wdata, mem_rdata});
    end
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_status busy/done got %b exp 00", {busy, done});
    end
    n_tests++;
    if ({mismatch_cnt, first_mm_cycle, mm_seen} !== '0) begin
      n_fail++; $display("FAIL reset_stats got %h exp 0", {mismatch_cnt, first_mm_cycle, mm_seen});
    end
    n_tests++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [ENT_W-1:0] e;
    build_exp(32'h100, '1);
    run_traffic(32'h100, '1, 0, -1, 0, -1, 0, 0, 0, 0, -1);
    n_tests++;
    if (timed_out || obs_q.size() != BEATS) begin
      n_fail++; $display("FAIL basic_beats got %0d (timeout %0d) exp %0d", obs_q.size(), timed_out, BEATS);
    end
    for (int k = 0; k < BEATS && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL basic_beat%0d got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    if (obs_q.size() > 7) begin
      e = obs_q[7];
      n_tests++;
      if (e[ENT_W-1 -: ADDR_W] !== 32'h11C || e[ENT_W-ADDR_W-1 -: STRB_W] !== 4'h0) begin
        n_fail++; $display("FAIL basic_beat7_addr got %h/%h exp 11c/0", e[ENT_W-1 -: ADDR_W], e[ENT_W-ADDR_W-1 -: STRB_W]);
      end
`ifndef MEM_TRAFFIC_LFSR_EN
      n_tests++;
      if (e[2*DATA_W-1 -: DATA_W] !== 32'd21) begin
        n_fail++; $display("FAIL basic_beat7_wdata got %0d exp 21", e[2*DATA_W-1 -: DATA_W]);
      end
`endif
    end
    n_tests++;
    if (busy_cnt != 16 || done_at != 17) begin
      n_fail++; $display("FAIL basic_timing busy %0d done_at %0d exp 16/17", busy_cnt, done_at);
    end
    n_tests++;
    if (done_pulses != 1) begin
      n_fail++; $display("FAIL basic_done_width got %0d exp 1", done_pulses);
    end
    n_tests++;
    if ({mismatch_cnt, mm_seen} !== '0) begin
      n_fail++; $display("FAIL basic_no_mm got %0d/%0d exp 0/0", mismatch_cnt, mm_seen);
    end
  endtask

  task automatic test_backpressure();
    int hold;
    build_exp(32'h100, '1);
    run_traffic(32'h100, '1, 0, 2, 3, -1, 0, 0, 0, 0, -1);
    n_tests++;
    if (busy_cnt != 19 || done_at != 20) begin
      n_fail++; $display("FAIL bp_timing busy %0d done_at %0d exp 19/20", busy_cnt, done_at);
    end
    hold = 0;
    foreach (cyc_bus_q[i]) if (cyc_bus_q[i] === exp_q[2]) hold++;
    n_tests++;
    if (hold != 4) begin
      n_fail++; $display("FAIL bp_hold beat2 shown %0d cycles exp 4", hold);
    end
    for (int k = 0; k < BEATS && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL bp_beat%0d got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [ENT_W-1:0] e;
    build_exp(32'h200, 32'hF);
    run_traffic(32'h200, 32'hF, 0, -1, 0, -1, 0, 0, 0, 0, -1);
    n_tests++;
    if (obs_q.size() != BEATS) begin
      n_fail++; $display("FAIL wrap_beats got %0d exp %0d", obs_q.size(), BEATS);
    end
    for (int k = 0; k < 5 && k < obs_q.size(); k++) begin
      e = obs_q[k];
      n_tests++;
      if (e[ENT_W-1 -: ADDR_W] !== 32'h200 + 32'((4 * k) % 16)) begin
        n_fail++; $display("FAIL wrap_addr%0d got %h exp %h", k, e[ENT_W-1 -: ADDR_W], 32'h200 + 32'((4 * k) % 16));
      end
    end
  endtask

  task automatic test_mismatch();
    run_traffic(32'h100, '1, 0, -1, 0, 5, 2, 0, 0, 0, -1);
    n_tests++;
    if (mismatch_cnt !== 4'd2 || first_mm_cycle !== 4'd5 || mm_seen !== 1'b1) begin
      n_fail++; $display("FAIL mm_stats got cnt %0d first %0d seen %0d exp 2/5/1", mismatch_cnt, first_mm_cycle, mm_seen);
    end
  endtask

  task automatic test_saturation();
    run_traffic(32'h100, '1, 0, 0, 20, 17, 1000, 0, 1, 0, -1);
    n_tests++;
    if (busy_cnt != 36) begin
      n_fail++; $display("FAIL sat_busy got %0d exp 36", busy_cnt);
    end
    n_tests++;
    if (mismatch_cnt !== 4'hF || first_mm_cycle !== 4'hF || mm_seen !== 1'b1) begin
      n_fail++; $display("FAIL sat_stats got cnt %0d first %0d seen %0d exp 15/15/1", mismatch_cnt, first_mm_cycle, mm_seen);
    end
  endtask

  task automatic test_reset_mid();
    run_traffic(32'h300, '1, 0, -1, 0, 1, 1, 0, 4, 0, 3);
    n_tests++;
    if (!rst_hit || rst_snap !== '0 || rst_stats !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs hit %0d got %h/%h exp 0", rst_hit, rst_snap, rst_stats);
    end
    n_tests++;
    if (done_pulses != 0) begin
      n_fail++; $display("FAIL rstmid_done got %0d pulses exp 0", done_pulses);
    end
    build_exp(32'h300, '1);
    run_traffic(32'h300, '1, 0, -1, 0, -1, 0, 0, 0, 0, -1);
    n_tests++;
    if (obs_q.size() != BEATS || obs_q[0] !== exp_q[0] || obs_q[BEATS-1] !== exp_q[BEATS-1]) begin
      n_fail++; $display("FAIL rstmid_restart beats %0d first %h exp %h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] b, m;
    int bad;
    for (int it = 0; it < 8; it++) begin
      b = $urandom;
      m = $urandom_range(0, 1) ? '1 : ADDR_W'($urandom_range(0, 255));
      build_exp(b, m);
      run_traffic(b, m, 1, -1, 0, -1, 0, 1, 0, 1, -1);
      bad = 0;
      for (int k = 0; k < BEATS && k < obs_q.size(); k++) if (obs_q[k] !== exp_q[k]) bad++;
      n_tests++;
      if (timed_out || obs_q.size() != BEATS || bad != 0) begin
        n_fail++; $display("FAIL rnd%0d_seq beats %0d bad %0d timeout %0d", it, obs_q.size(), bad, timed_out);
      end
      n_tests++;
      if (busy_cnt != BEATS + stall_cycles || done_pulses != 1) begin
        n_fail++; $display("FAIL rnd%0d_timing busy %0d exp %0d done %0d", it, busy_cnt, BEATS + stall_cycles, done_pulses);
      end
      n_tests++;
      if (mismatch_cnt !== CNT_W'(exp_mm) || mm_seen !== exp_seen || (exp_seen && first_mm_cycle !== CNT_W'(exp_first))) begin
        n_fail++; $display("FAIL rnd%0d_stats got %0d/%0d/%0d exp %0d/%0d/%0d", it, mismatch_cnt, first_mm_cycle, mm_seen, exp_mm, exp_first, exp_seen);
      end
    end
  endtask

`ifdef MEM_TRAFFIC_LFSR_EN
  task automatic test_lfsr();
    run_traffic(32'h0, '1, 0, -1, 0, -1, 0, 0, 0, 0, -1);
    n_tests++;
    if (obs_q.size() < 1 || obs_q[0][2*DATA_W-1:0] !== {32'h1, 32'h8000_0000}) begin
      n_fail++; $display("FAIL lfsr_seed got %h exp 0000000180000000", obs_q.size() ? obs_q[0][2*DATA_W-1:0] : '0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_mismatch();
    test_saturation();
    test_reset_mid();
    test_random();
`ifdef MEM_TRAFFIC_LFSR_EN
    test_lfsr();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_traffic_gen.md
Name: mem_traffic_gen

Overview:
- Synthesizable, parametrised successor to the hand-written cache stimulus bench.
- Drives a PicoRV32-style memory request bus (valid/ready/addr/wstrb/wdata) plus an emulated memory read-data return in alternating write/read phases, honouring ready backpressure.
- Compares two copies of the downstream cache output bus, behavioural against structural, cycle by cycle, and reports mismatch statistics.
- Sits between the test top and the two cache instances.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- STRB_W, DATA_W/8, write-strobe width (derived).
- PHASE_LEN, 500, accepted beats per write or read phase; at least 1.
- NUM_ROUNDS, 6, write+read phase pairs per run; at least 1.
- ADDR_STRIDE, 4, address increment per accepted beat.
- DATA_STEP, 3, wdata/rdata increment per accepted beat.
- CNT_W, 16, width of the mismatch and cycle counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a run when idle.
- addr_base  in  ADDR_W  first address; sampled on start.
- addr_mask  in  ADDR_W  offset wrap mask; sampled on start.
- mem_ready  in  1  downstream accepts the current beat.
- mem_valid  out  1  request valid.
- mem_addr  out  ADDR_W  request address.
- mem_wstrb  out  STRB_W  all ones in write phase, zero in read phase.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  out  DATA_W  emulated memory return data.
- cmp_a_valid, cmp_b_valid  in  1  output valid of the behavioural and structural instances.
- cmp_a_ready, cmp_b_ready  in  1  output ready of each instance.
- cmp_a_addr, cmp_b_addr  in  ADDR_W  output address of each instance.
- cmp_a_wstrb, cmp_b_wstrb  in  STRB_W  output write strobe of each instance.
- cmp_a_wdata, cmp_b_wdata  in  DATA_W  output write data of each instance.
- cmp_a_rdata, cmp_b_rdata  in  DATA_W  output read data of each instance.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- mismatch_cnt  out  CNT_W  saturating count of mismatching cycles.
- first_mm_cycle  out  CNT_W  run cycle of the first mismatch.
- mm_seen  out  1  sticky; set at the first mismatch.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters cleared.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - start=1 latches addr_base and addr_mask, clears offset, beat counter, round counter, mismatch_cnt, mm_seen, first_mm_cycle and the cycle counter.
  - Next cycle: WRITE, mem_valid=1, mem_addr=addr_base, mem_wdata=0, mem_rdata=0.
- WRITE/READ handshake:
  - A beat is accepted on a cycle with mem_valid & mem_ready.
  - While not accepted, addr, wstrb, wdata and rdata hold stable.
  - On accept: offset += ADDR_STRIDE; mem_addr = addr_base + (offset & addr_mask), computed modulo 2^ADDR_W; wdata and rdata += DATA_STEP, modulo 2^DATA_W; beat counter increments.
- Phase switching:
  - Accept of beat PHASE_LEN-1 in WRITE -> READ; beat counter cleared.
  - Accept of beat PHASE_LEN-1 in READ: round counter increments. If rounds < NUM_ROUNDS -> WRITE; otherwise -> DONE.
  - Address and data keep progressing across phases; they are not reset between phases.
  - mem_valid stays 1 across the phase switch, so there are no bubbles.
- DONE: lasts one cycle. done=1, mem_valid=0, addr/wstrb/wdata/rdata=0. Then IDLE.
- busy=1 in WRITE and READ only.
- start is ignored while busy.
- Checker:
  - Active while busy.
  - A mismatch cycle is one where (cmp_a_valid | cmp_b_valid) and any of valid, ready, addr, wstrb, wdata or rdata differ between A and B.
  - Each mismatch cycle increments mismatch_cnt, saturating at all ones.
  - On the first mismatch: mm_seen=1 and first_mm_cycle = the cycle counter value, counted from 0 at the first WRITE cycle.
  - The cycle counter saturates.
  - Statistics hold after DONE until the next start.
- Reset asserted mid-run: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro: MEM_TRAFFIC_LFSR_EN.
- Defined: wdata and rdata come from a DATA_W-bit maximal-length Galois LFSR.
  - Seed 1 on start.
  - Advances once per accepted beat.
  - rdata uses the LFSR value bit-reversed.
- Undefined: the incrementing DATA_STEP pattern above.

Decomposition:
- Package mem_traffic_pkg: FSM state enum (2-bit); LFSR tap constants for 32 and 64 bits; a helper function for the saturating increment.
- One sub-module, mem_bus_cmp: the combinational mismatch detect plus the registered statistics (mismatch_cnt, mm_seen, first_mm_cycle).

Test Plan:
- Parameters PHASE_LEN=4, NUM_ROUNDS=2. mem_ready=1, addr_base=0x100, addr_mask=all ones, start pulse:
  - Addresses are 0x100, 0x104, …, 0x11C.
  - wstrb is 0xF for beats 0-3 and 0 for beats 4-7, then repeats.
  - wdata is 0, 3, …, 21.
  - done pulses at cycle 17; busy covers exactly 16 cycles.
- mem_ready low for 3 cycles at beat 2 -> the beat 2 outputs hold for 3 cycles; total busy increases by exactly 3.
- addr_mask=0xF, addr_base=0x200 -> addresses run 0x200, 0x204, 0x208, 0x20C, 0x200.
- B wdata forced different from A at run cycle 5 for 2 cycles -> mismatch_cnt=2, first_mm_cycle=5, mm_seen=1.
- reset asserted at beat 3 -> all outputs 0 the same cycle, no done pulse. A new start restarts from addr_base.
- With MEM_TRAFFIC_LFSR_EN defined -> wdata sequence matches the reference LFSR model from seed 1; rdata is its bit reversal.
